multiword_add_seq: RTL and testbench
====================================

Name: multiword_add_seq

Overview:
- Sequential multi-precision adder/subtractor. Reuses one N-bit adder slice over WORDS cycles to add or subtract N*WORDS-bit operands, least-significant word first, chaining the carry through a register.
- Sits between register-file/ALU control and the N-bit adder primitive.
- Trades latency for area when operand width exceeds one adder slice.

Parameters:
- N, 4, width of one adder slice (bits per word).
- WORDS, 4, number of words per operand; total width W = N*WORDS; WORDS >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a new operation; sampled only when ready=1.
- sub  in  1  0: A+B+c_in; 1: A-B (A + ~B + 1, c_in ignored).
- a  in  W  operand A; captured on the accepted start.
- b  in  W  operand B; captured on the accepted start.
- c_in  in  1  carry-in for add mode.
- ready  out  1  high in IDLE and DONE; start accepted when high.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse; result valid.
- sum  out  W  result register; holds its value until the next accepted start completes words.
- c_out  out  1  final carry. In sub mode, 1 = no borrow.
- ovf  out  1  two's-complement signed overflow of the full-W result.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, ready=1, busy=0, done=0, sum=0, c_out=0, ovf=0, word index=0, carry register=0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at a rising edge → capture operands:
  - A_reg = a.
  - B_reg = sub ? ~b : b.
  - carry = sub ? 1 : c_in.
  - idx = 0, sub_reg = sub.
  - Go to RUN.
- RUN, each edge:
  - Slice adds A_reg word idx + B_reg word idx + carry.
  - Write the slice sum into sum word idx; carry register = slice carry-out.
  - idx increments.
  - On idx == WORDS-1: also write c_out and ovf, then go to DONE.
- ovf = (A_msb == B_reg_msb) && (sum_msb != A_msb), where B_reg_msb is the post-inversion MSB.
- DONE: lasts one cycle with done=1, ready=1.
  - start=1 → accepted exactly as in IDLE, go to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- Latency: start accepted at edge t → done=1 in the cycle following edge t+WORDS; throughput one op per WORDS+1 cycles.
- start while busy=1: ignored; no queuing; a/b/sub/c_in are don't-care.
- Operands are captured, so a/b may change after acceptance without effect.
- sum, c_out, ovf hold from done until the final edge of the next operation. Lower words of sum update progressively during RUN; consumers sample only on done.
- Word index counter width: clog2(WORDS); no wrap beyond WORDS-1.
- Reset mid-RUN: abort immediately to the reset values; partial results are discarded.

Optional Feature:
- Macro MWADD_ACC_EN.
- Defined:
  - Adds input port acc (1 bit), sampled with start.
  - acc=1 → operand A is taken from the current sum register instead of port a, giving accumulate or decrement-by-B.
  - acc=0 → normal behaviour.
- Undefined: port acc is absent; A is always port a.

Decomposition:
- Shared package mwadd_pkg:
  - state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - index-width helper function (clog2).
- Sub-module: one instance of the team's N-bit adder slice (a, b, c_in → sum, c_out), parameterised with N.
- FSM, operand registers and word mux stay in multiword_add_seq.

Test Plan:
All cases use N=4, WORDS=4 (W=16).
- Add, basic: a=0x1234, b=0x0FCD, c_in=0, sub=0 → done exactly 4 cycles after acceptance; sum=0x2201, c_out=0, ovf=0.
- Add, wrap: a=0xFFFF, b=0x0001 → sum=0x0000, c_out=1, ovf=0.
- Add, signed overflow: a=0x7FFF, b=0x0001 → sum=0x8000, c_out=0, ovf=1.
- Subtract:
  - a=0x0005, b=0x0007 → sum=0xFFFE, c_out=0, ovf=0.
  - a=0x8000, b=0x0001 → sum=0x7FFF, c_out=1, ovf=1.
- Handshake:
  - start held during RUN → ignored; busy=1, ready=0.
  - start on the done cycle with a=0x0001, b=0x0002 → second done 5 cycles after the first; sum=0x0003.
- Reset mid-RUN: reset asserted asynchronously after 2 RUN cycles → all outputs 0, ready=1 immediately. A following op 0x00FF+0x0001 gives 0x0100.
- With MWADD_ACC_EN: op 0x0010+0x0005, then acc=1 with b=0x0003 → sum=0x0018.

Source files
------------

// File: rtl/multiword_add_seq_pkg.sv
// Shared types and helpers for the sequential multi-precision adder/subtractor.
package mwadd_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Word-index width; never narrower than one bit so WORDS=1 builds still elaborate
  function automatic int idx_width(input int words);
    int w;
    w = 1;
    while ((1 << w) < words) w++;
    return w;
  endfunction

endpackage

// File: rtl/multiword_add_seq_if.sv
// Operation handshake and result bus for multiword_add_seq.
// Carries the acc request only when MWADD_ACC_EN is defined.
interface multiword_add_seq_if
  import mwadd_pkg::*;
#(
  parameter int N     = 4,
  parameter int WORDS = 4
);
  localparam int W = N * WORDS;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
`ifdef MWADD_ACC_EN
  logic         acc;
`endif
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  modport master (
`ifdef MWADD_ACC_EN
    output acc,
`endif
    output start, sub, a, b, c_in,
    input  ready, busy, done, sum, c_out, ovf
  );

  modport slave (
`ifdef MWADD_ACC_EN
    input  acc,
`endif
    input  start, sub, a, b, c_in,
    output ready, busy, done, sum, c_out, ovf
  );

endinterface

// File: rtl/multiword_add_seq_slice.sv
// One N-bit ripple adder slice; the sequencer reuses it once per operand word.
module multiword_add_seq_slice
  import mwadd_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);

  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential N*WORDS-bit add/subtract over one N-bit slice, LS word first.
// Optional MWADD_ACC_EN: acc=1 on start takes operand A from the current sum.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | waiting for start; ready=1
//  RUN    | one slice add per edge, word idx, carry chained in register
//  DONE   | one-cycle done pulse; ready=1, start here runs back-to-back
module multiword_add_seq
  import mwadd_pkg::*;
#(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                reset,
  multiword_add_seq_if.slave  bus
);

  localparam int              IW       = idx_width(WORDS);
  localparam logic [IW-1:0]   LAST_IDX = IW'(WORDS - 1);

  state_t                     state;
  logic [IW-1:0]              idx;
  logic                       carry;
  logic [WORDS-1:0][N-1:0]    a_reg;
  logic [WORDS-1:0][N-1:0]    b_reg;
  logic [WORDS-1:0][N-1:0]    sum_r;
  logic [WORDS-1:0][N-1:0]    a_next;
  logic                       c_out_r;
  logic                       ovf_r;
  logic                       ready_r;
  logic                       busy_r;
  logic                       done_r;

  logic [N-1:0]               slice_sum;
  logic                       slice_cout;

`ifdef MWADD_ACC_EN
  assign a_next = bus.acc ? sum_r : bus.a;
`else
  assign a_next = bus.a;
`endif

  multiword_add_seq_slice #(.N(N)) u_slice (
    .a     (a_reg[idx]),
    .b     (b_reg[idx]),
    .c_in  (carry),
    .sum   (slice_sum),
    .c_out (slice_cout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      idx     <= '0;
      carry   <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      sum_r   <= '0;
      c_out_r <= 1'b0;
      ovf_r   <= 1'b0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
          state   <= S_IDLE;
          if (bus.start) begin
            a_reg   <= a_next;
            b_reg   <= bus.sub ? ~bus.b : bus.b;
            // subtract is A + ~B + 1, so the inverted-operand +1 rides in as carry
            carry   <= bus.sub | bus.c_in;
            idx     <= '0;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          sum_r[idx] <= slice_sum;
          carry      <= slice_cout;
          if (idx == LAST_IDX) begin
            c_out_r <= slice_cout;
            ovf_r   <= (a_reg[WORDS-1][N-1] == b_reg[WORDS-1][N-1]) &&
                       (slice_sum[N-1] != a_reg[WORDS-1][N-1]);
            done_r  <= 1'b1;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            state   <= S_DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: begin
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ready = ready_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.sum   = sum_r;
  assign bus.c_out = c_out_r;
  assign bus.ovf   = ovf_r;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq (N=4, WORDS=4); covers MWADD_ACC_EN when defined.
module tb_multiword_add_seq;

  localparam int N     = 4;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  multiword_add_seq_if #(.N(N), .WORDS(WORDS)) bus ();

  multiword_add_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         c_in;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Start at a negedge, accept on the next posedge, then count edges to done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic c_in, input logic acc,
                        output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.sub   = sub;
    bus.c_in  = c_in;
`ifdef MWADD_ACC_EN
    bus.acc   = acc;
`else
    if (acc) $display("note: acc requested but MWADD_ACC_EN undefined");
`endif
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = ~b;
    check("busy_after_accept", bus.busy, 1);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h00FF, 16'h0F00, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0};
    vecs[6] = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.c_in  = 1'b0;
`ifdef MWADD_ACC_EN
    bus.acc   = 1'b0;
`endif
    #1;
    check("rst_ready", bus.ready, 1);
    check("rst_busy",  bus.busy,  0);
    check("rst_done",  bus.done,  0);
    check("rst_sum",   bus.sum,   0);
    check("rst_cout",  bus.c_out, 0);
    check("rst_ovf",   bus.ovf,   0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // start held through RUN, then a second op accepted on the done cycle
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 16'h1234; bus.b = 16'h0FCD; bus.sub = 1'b0; bus.c_in = 1'b0;
    @(posedge clk);
    #1;
    bus.a = 16'hAAAA; bus.b = 16'h5555; bus.sub = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("held_busy",  bus.busy,  1);
      check("held_ready", bus.ready, 0);
      check("held_done",  bus.done,  0);
    end
    @(posedge clk);
    #1;
    check("hs_done1",  bus.done,  1);
    check("hs_ready1", bus.ready, 1);
    check("hs_sum1",   bus.sum,   16'h2201);
    bus.a = 16'h0001; bus.b = 16'h0002; bus.sub = 1'b0; bus.c_in = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) bus.start = 1'b0;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    check("hs_b2b_latency", lat, 5);
    check("hs_sum2", bus.sum, 16'h0003);

    for (int v = 0; v < 8; v++) begin
      run_op(vecs[v].a, vecs[v].b, vecs[v].sub, vecs[v].c_in, 1'b0, lat);
      check("vec_latency", lat, 4);
      check("vec_sum",  bus.sum,   vecs[v].exp_sum);
      check("vec_cout", bus.c_out, vecs[v].exp_cout);
      check("vec_ovf",  bus.ovf,   vecs[v].exp_ovf);
    end
    @(posedge clk);
    #1;
    check("hold_done_low", bus.done,  0);
    check("hold_ready",    bus.ready, 1);
    check("hold_sum",      bus.sum,   16'h0000);
    check("hold_cout",     bus.c_out, 1);
    check("hold_ovf",      bus.ovf,   1);

    // abort two RUN edges into an operation
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 16'h1234; bus.b = 16'h0FCD; bus.sub = 1'b0; bus.c_in = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_run_busy", bus.busy, 1);
    check("mid_run_partial_sum", bus.sum, 16'h0001);
    #2;
    reset = 1'b1;
    #1;
    check("abort_ready", bus.ready, 1);
    check("abort_busy",  bus.busy,  0);
    check("abort_done",  bus.done,  0);
    check("abort_sum",   bus.sum,   0);
    check("abort_cout",  bus.c_out, 0);
    check("abort_ovf",   bus.ovf,   0);
    @(negedge clk);
    reset = 1'b0;
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, lat);
    check("post_abort_latency", lat, 4);
    check("post_abort_sum", bus.sum, 16'h0100);
    check("post_abort_cout", bus.c_out, 0);

`ifdef MWADD_ACC_EN
    run_op(16'h0010, 16'h0005, 1'b0, 1'b0, 1'b0, lat);
    check("acc_first_sum", bus.sum, 16'h0015);
    run_op(16'hFFFF, 16'h0003, 1'b0, 1'b0, 1'b1, lat);
    check("acc_latency", lat, 4);
    check("acc_sum", bus.sum, 16'h0018);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
